// File: rtl/mutative_flush_engine_if.sv
// Request, array-port and writeback-port bundle of the mutative cache flush engine.
// master is the engine side; slave is the cache/memory side.
interface mutative_flush_engine_if #(
  parameter int WAYS       = 8,
  parameter int SET_BITS   = 4,
  parameter int TAG_BITS   = 23,
  parameter int LINE_BITS  = 256,
  parameter int SETUP_BITS = 2
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_mode;
  logic [SETUP_BITS-1:0]     req_setup;
  logic [SETUP_BITS-1:0]     setup;
  logic                      busy;
  logic                      done;

  logic                      arr_csb;
  logic [SET_BITS-1:0]       arr_set;
  logic [WAYS-1:0]           arr_inv;
  logic [WAYS-1:0]           arr_clean;
  logic [WAYS-1:0]           arr_valid;
  logic [WAYS-1:0]           arr_dirty;
  logic [WAYS*TAG_BITS-1:0]  arr_tag;
  logic [WAYS*LINE_BITS-1:0] arr_data;

  logic [31:0]               dfp_addr;
  logic                      dfp_write;
  logic [LINE_BITS-1:0]      dfp_wdata;
  logic                      dfp_resp;

  modport master (
    input  req_valid, req_mode, req_setup,
    input  arr_valid, arr_dirty, arr_tag, arr_data, dfp_resp,
    output req_ready, setup, busy, done,
    output arr_csb, arr_set, arr_inv, arr_clean,
    output dfp_addr, dfp_write, dfp_wdata
  );

  modport slave (
    output req_valid, req_mode, req_setup,
    output arr_valid, arr_dirty, arr_tag, arr_data, dfp_resp,
    input  req_ready, setup, busy, done,
    input  arr_csb, arr_set, arr_inv, arr_clean,
    input  dfp_addr, dfp_write, dfp_wdata
  );
endinterface

// File: rtl/mutative_flush_engine.sv
// Walks every set on a reconfiguration request, writes back dirty lines lowest way first,
// then invalidates (mode 0) or cleans (mode 1) them and commits the new setup code.
module mutative_flush_engine #(
  parameter int WAYS        = 8,
  parameter int SETS        = 16,
  parameter int LINE_BITS   = 256,
  parameter int SETUP_BITS  = 2,
  parameter int RESET_SETUP = 0
) (
  input logic                   clk,
  input logic                   rst,
  mutative_flush_engine_if.master bus
);
  localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
  localparam int SET_BITS    = $clog2(SETS);
  localparam int TAG_BITS    = 32 - SET_BITS - OFFSET_BITS;
  localparam int WAY_BITS    = $clog2(WAYS);
  localparam logic [SETUP_BITS-1:0] SETUP_INIT = SETUP_BITS'(RESET_SETUP);

  typedef enum logic [2:0] {
    IDLE, SKIP, READ, CAPTURE, WB, UPDATE, NEXT, DONE
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [SET_BITS-1:0]   counter;
  logic [WAYS-1:0]       mask;
  logic [WAYS-1:0]       valid_cap;
  logic [WAYS-1:0]       dirty_cap;
  logic                  mode;
  logic [SETUP_BITS-1:0] pend_setup;
  logic [SETUP_BITS-1:0] setup_reg;
  logic                  done_reg;
  logic [WAY_BITS-1:0]   way;
  logic [WAYS-1:0]       way_bit;
  logic                  accept;
  logic                  skip;

  assign accept  = bus.req_valid && (state == IDLE);
  assign skip    = (bus.req_setup == setup_reg) && !bus.req_mode;
  assign way_bit = WAYS'(1) << way;

  // Descending scan so the lowest dirty way wins.
  always_comb begin
    way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (mask[i]) way = WAY_BITS'(i);
    end
  end

  always_comb begin
    next_state    = state;
    bus.req_ready = 1'b0;
    bus.arr_csb   = 1'b1;
    bus.arr_set   = counter;
    bus.arr_inv   = '0;
    bus.arr_clean = '0;
    bus.dfp_write = 1'b0;
    bus.dfp_addr  = '0;
    bus.dfp_wdata = '0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) next_state = skip ? SKIP : READ;
      end
      SKIP: next_state = IDLE;
      READ: begin
        bus.arr_csb = 1'b0;
        next_state  = CAPTURE;
      end
      CAPTURE: next_state = (|(bus.arr_valid & bus.arr_dirty)) ? WB : UPDATE;
      WB: begin
        // Array outputs hold while csb is high, so tag/data stay stable through the stall.
        bus.dfp_write = 1'b1;
        bus.dfp_addr  = {bus.arr_tag[int'(way)*TAG_BITS +: TAG_BITS], counter,
                         {OFFSET_BITS{1'b0}}};
        bus.dfp_wdata = bus.arr_data[int'(way)*LINE_BITS +: LINE_BITS];
        if (bus.dfp_resp && ((mask & ~way_bit) == '0)) next_state = UPDATE;
      end
      UPDATE: begin
        bus.arr_csb = 1'b0;
        if (mode) bus.arr_clean = dirty_cap;
        else      bus.arr_inv   = valid_cap;
        next_state = NEXT;
      end
      NEXT: next_state = (counter == SET_BITS'(SETS - 1)) ? DONE : READ;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      setup_reg  <= SETUP_INIT;
      pend_setup <= SETUP_INIT;
      mode       <= 1'b0;
      done_reg   <= 1'b0;
      counter    <= '0;
      mask       <= '0;
      valid_cap  <= '0;
      dirty_cap  <= '0;
    end else begin
      state    <= next_state;
      // Skip completes in the cycle after acceptance; a full flush one cycle after DONE,
      // together with the committed setup code.
      done_reg <= (accept && skip) || (state == DONE);
      if (accept) begin
        mode       <= bus.req_mode;
        pend_setup <= bus.req_setup;
        counter    <= '0;
      end
      if (state == CAPTURE) begin
        mask      <= bus.arr_valid & bus.arr_dirty;
        valid_cap <= bus.arr_valid;
        dirty_cap <= bus.arr_valid & bus.arr_dirty;
      end
      if (state == WB && bus.dfp_resp) mask <= mask & ~way_bit;
      if (state == NEXT) counter <= counter + 1'b1;
      if (state == DONE) setup_reg <= pend_setup;
    end
  end

  assign bus.setup = setup_reg;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_reg;
endmodule

// File: tb/tb_mutative_flush_engine.sv
// Directed bench: synchronous array model plus a delayed-ack memory, one task per scenario.
`timescale 1ns/1ps
module tb_mutative_flush_engine;
  localparam int WAYS = 8, SETS = 16, LINE_BITS = 256, SETUP_BITS = 2;
  localparam int SET_BITS = 4, TAG_BITS = 23;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mutative_flush_engine_if #(.WAYS(WAYS), .SET_BITS(SET_BITS), .TAG_BITS(TAG_BITS),
                             .LINE_BITS(LINE_BITS), .SETUP_BITS(SETUP_BITS)) bus();

  mutative_flush_engine #(.WAYS(WAYS), .SETS(SETS), .LINE_BITS(LINE_BITS),
                          .SETUP_BITS(SETUP_BITS), .RESET_SETUP(0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [WAYS-1:0]           mem_valid [SETS];
  logic [WAYS-1:0]           mem_dirty [SETS];
  logic [TAG_BITS-1:0]       mem_tag   [SETS][WAYS];
  logic [WAYS*TAG_BITS-1:0]  tag_rd;
  logic [WAYS*LINE_BITS-1:0] data_rd;

  function automatic logic [LINE_BITS-1:0] line_of(input int s, input int w);
    logic [31:0] word;
    word = 32'hC0DE_0000 | 32'(s * 16 + w);
    return {8{word}};
  endfunction

  // Synchronous array: read on csb low, output held otherwise; strobes apply after the read.
  always @(posedge clk) begin
    if (!bus.arr_csb) begin
      for (int w = 0; w < WAYS; w++) begin
        tag_rd[w*TAG_BITS +: TAG_BITS]    = mem_tag[bus.arr_set][w];
        data_rd[w*LINE_BITS +: LINE_BITS] = line_of(int'(bus.arr_set), w);
      end
      bus.arr_valid <= mem_valid[bus.arr_set];
      bus.arr_dirty <= mem_dirty[bus.arr_set];
      bus.arr_tag   <= tag_rd;
      bus.arr_data  <= data_rd;
      mem_valid[bus.arr_set] = mem_valid[bus.arr_set] & ~bus.arr_inv;
      mem_dirty[bus.arr_set] = mem_dirty[bus.arr_set] & ~bus.arr_inv & ~bus.arr_clean;
    end
  end

  // Memory acknowledges each write resp_delay+1 cycles after it is presented.
  int resp_delay = 0;
  int wait_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt     <= 0;
      bus.dfp_resp <= 1'b0;
    end else if (bus.dfp_write && !bus.dfp_resp) begin
      if (wait_cnt >= resp_delay) begin
        bus.dfp_resp <= 1'b1;
        wait_cnt     <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      bus.dfp_resp <= 1'b0;
    end
  end

  logic [31:0]          wr_addr [$];
  logic [LINE_BITS-1:0] wr_data [$];
  logic [WAYS-1:0]      inv_log   [SETS];
  logic [WAYS-1:0]      clean_log [SETS];
  int   unstable, conflicts, busy_cycles, csb_cycles, lat, first_set;
  logic got_done;

  task automatic clear_arrays();
    for (int s = 0; s < SETS; s++) begin
      mem_valid[s] = '0;
      mem_dirty[s] = '0;
      for (int w = 0; w < WAYS; w++) mem_tag[s][w] = TAG_BITS'(32'h1000 + s * 16 + w);
    end
  endtask

  // Issues one request and records activity until done (lat counts edges incl. acceptance).
  task automatic run_req(input logic mode, input logic [1:0] su, input int budget);
    logic pend;
    logic [31:0] pa;
    logic [LINE_BITS-1:0] pd;
    wr_addr.delete();
    wr_data.delete();
    for (int s = 0; s < SETS; s++) begin
      inv_log[s]   = '0;
      clean_log[s] = '0;
    end
    unstable = 0; conflicts = 0; busy_cycles = 0; csb_cycles = 0;
    lat = 0; first_set = -1; got_done = 1'b0;
    pend = 1'b0; pa = '0; pd = '0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_mode  = mode;
    bus.req_setup = su;
    while (!got_done && lat < budget) begin
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      lat++;
      if (bus.busy) busy_cycles++;
      if (!bus.arr_csb) begin
        csb_cycles++;
        if (first_set < 0) first_set = int'(bus.arr_set);
        inv_log[bus.arr_set]   = inv_log[bus.arr_set] | bus.arr_inv;
        clean_log[bus.arr_set] = clean_log[bus.arr_set] | bus.arr_clean;
      end
      if (pend && (!bus.dfp_write || bus.dfp_addr !== pa || bus.dfp_wdata !== pd)) unstable++;
      if (bus.dfp_write && !bus.arr_csb) conflicts++;
      if ((|bus.arr_inv) && (|bus.arr_clean)) conflicts++;
      if (bus.dfp_write && bus.dfp_resp) begin
        wr_addr.push_back(bus.dfp_addr);
        wr_data.push_back(bus.dfp_wdata);
      end
      pend = bus.dfp_write && !bus.dfp_resp;
      pa   = bus.dfp_addr;
      pd   = bus.dfp_wdata;
      if (bus.done) got_done = 1'b1;
    end
    vectors++;
    if (!got_done) begin
      miscompares++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.dfp_write, bus.arr_csb} !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy/done/write/csb=%b expected 0001",
               {bus.busy, bus.done, bus.dfp_write, bus.arr_csb});
    end
    vectors++;
    if (bus.setup !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_setup: got %0d expected 0", bus.setup);
    end
    vectors++;
    if (bus.arr_inv !== '0 || bus.arr_clean !== '0) begin
      miscompares++;
      $display("FAIL reset_strobes: inv=%h clean=%h expected 00/00", bus.arr_inv, bus.arr_clean);
    end
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected 1", bus.req_ready);
    end
  endtask

  task automatic test_clean_flush();
    logic any_left;
    clear_arrays();
    for (int s = 0; s < SETS; s++) mem_valid[s] = WAYS'(s * 37 + 1);
    resp_delay = 0;
    run_req(1'b0, 2'd3, 300);
    vectors++;
    if (lat !== 66) begin
      miscompares++;
      $display("FAIL clean_latency: got %0d expected 66", lat);
    end
    vectors++;
    if (wr_addr.size() !== 0) begin
      miscompares++;
      $display("FAIL clean_writes: got %0d expected 0", wr_addr.size());
    end
    vectors++;
    if (bus.setup !== 2'd3) begin
      miscompares++;
      $display("FAIL clean_setup: got %0d expected 3", bus.setup);
    end
    vectors++;
    if (busy_cycles !== 65) begin
      miscompares++;
      $display("FAIL clean_busy: got %0d expected 65", busy_cycles);
    end
    for (int s = 0; s < SETS; s++) begin
      vectors++;
      if (inv_log[s] !== WAYS'(s * 37 + 1)) begin
        miscompares++;
        $display("FAIL clean_inv_set%0d: got %h expected %h", s, inv_log[s], WAYS'(s * 37 + 1));
      end
    end
    any_left = 1'b0;
    for (int s = 0; s < SETS; s++) any_left = any_left | (|mem_valid[s]);
    vectors++;
    if (any_left !== 1'b0) begin
      miscompares++;
      $display("FAIL clean_invalidated: valid lines left=%b expected 0", any_left);
    end
  endtask

  task automatic test_single_dirty();
    clear_arrays();
    mem_valid[3]    = 8'h2C;
    mem_dirty[3]    = 8'h21;   // way 0 dirty but invalid: must not be written
    mem_tag[3][5]   = 23'h12345;
    resp_delay = 0;
    run_req(1'b0, 2'd1, 300);
    vectors++;
    if (wr_addr.size() !== 1) begin
      miscompares++;
      $display("FAIL single_count: got %0d expected 1", wr_addr.size());
    end else begin
      vectors++;
      if (wr_addr[0] !== 32'h0246_8A60) begin
        miscompares++;
        $display("FAIL single_addr: got %h expected 02468a60", wr_addr[0]);
      end
      vectors++;
      if (wr_data[0] !== line_of(3, 5)) begin
        miscompares++;
        $display("FAIL single_data: got %h expected %h", wr_data[0], line_of(3, 5));
      end
    end
    vectors++;
    if (inv_log[3] !== 8'h2C) begin
      miscompares++;
      $display("FAIL single_inv: got %h expected 2c", inv_log[3]);
    end
    vectors++;
    if (lat !== 68) begin
      miscompares++;
      $display("FAIL single_latency: got %0d expected 68", lat);
    end
  endtask

  task automatic test_multi_dirty();
    logic [31:0] exp_addr [3];
    int exp_way [3];
    exp_addr[0] = 32'h0015_54E0; exp_addr[1] = 32'h0177_76E0; exp_addr[2] = 32'hFFFF_FEE0;
    exp_way[0] = 1; exp_way[1] = 4; exp_way[2] = 6;
    clear_arrays();
    mem_valid[7]  = 8'h56;
    mem_dirty[7]  = 8'h52;
    mem_tag[7][1] = 23'h000AAA;
    mem_tag[7][4] = 23'h00BBBB;
    mem_tag[7][6] = 23'h7FFFFF;
    resp_delay = 9;
    run_req(1'b0, 2'd2, 400);
    vectors++;
    if (wr_addr.size() !== 3) begin
      miscompares++;
      $display("FAIL multi_count: got %0d expected 3", wr_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== line_of(7, exp_way[i])) begin
          miscompares++;
          $display("FAIL multi_write%0d: addr %h expected %h (way %0d)", i, wr_addr[i],
                   exp_addr[i], exp_way[i]);
        end
      end
    end
    vectors++;
    if (unstable !== 0 || conflicts !== 0) begin
      miscompares++;
      $display("FAIL multi_stability: unstable=%0d conflicts=%0d expected 0/0", unstable, conflicts);
    end
    vectors++;
    if (lat !== 99) begin
      miscompares++;
      $display("FAIL multi_latency: got %0d expected 99", lat);
    end
    vectors++;
    if (inv_log[7] !== 8'h56) begin
      miscompares++;
      $display("FAIL multi_inv: got %h expected 56", inv_log[7]);
    end
  endtask

  task automatic test_skip();
    run_req(1'b0, 2'd2, 20);
    vectors++;
    if (lat !== 1 || busy_cycles !== 1 || csb_cycles !== 0) begin
      miscompares++;
      $display("FAIL skip_timing: lat=%0d busy=%0d csb=%0d expected 1/1/0", lat, busy_cycles,
               csb_cycles);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.setup !== 2'd2) begin
      miscompares++;
      $display("FAIL skip_after: busy=%b done=%b setup=%0d expected 0/0/2", bus.busy, bus.done,
               bus.setup);
    end
  endtask

  task automatic test_clean_mode();
    logic any_inv;
    clear_arrays();
    mem_valid[0]  = 8'h91;
    mem_dirty[0]  = 8'h81;
    mem_tag[0][0] = 23'h1;
    mem_tag[0][7] = 23'h2;
    mem_valid[15] = 8'h0F;
    mem_dirty[15] = 8'h08;
    mem_tag[15][3] = 23'h3;
    resp_delay = 2;
    run_req(1'b1, 2'd1, 400);
    vectors++;
    if (wr_addr.size() !== 3) begin
      miscompares++;
      $display("FAIL cmode_count: got %0d expected 3", wr_addr.size());
    end else begin
      vectors++;
      if (wr_addr[0] !== 32'h200 || wr_addr[1] !== 32'h400 || wr_addr[2] !== 32'h7E0) begin
        miscompares++;
        $display("FAIL cmode_addr: got %h %h %h expected 200 400 7e0", wr_addr[0], wr_addr[1],
                 wr_addr[2]);
      end
    end
    vectors++;
    if (clean_log[0] !== 8'h81 || clean_log[15] !== 8'h08) begin
      miscompares++;
      $display("FAIL cmode_clean: got %h/%h expected 81/08", clean_log[0], clean_log[15]);
    end
    any_inv = 1'b0;
    for (int s = 0; s < SETS; s++) any_inv = any_inv | (|inv_log[s]);
    vectors++;
    if (any_inv !== 1'b0) begin
      miscompares++;
      $display("FAIL cmode_inv: inv seen=%b expected 0", any_inv);
    end
    vectors++;
    if (mem_valid[0] !== 8'h91 || mem_dirty[0] !== 8'h00 || mem_dirty[15] !== 8'h00) begin
      miscompares++;
      $display("FAIL cmode_array: valid0=%h dirty0=%h dirty15=%h expected 91/00/00",
               mem_valid[0], mem_dirty[0], mem_dirty[15]);
    end
    vectors++;
    if (bus.setup !== 2'd1 || lat !== 78) begin
      miscompares++;
      $display("FAIL cmode_done: setup=%0d lat=%0d expected 1/78", bus.setup, lat);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_arrays();
    mem_valid[5] = 8'h04; mem_dirty[5] = 8'h04; mem_tag[5][2] = 23'h55;
    mem_valid[9] = 8'h01; mem_dirty[9] = 8'h01; mem_tag[9][0] = 23'h99;
    resp_delay = 50;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_mode = 1'b0; bus.req_setup = 2'd3;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.dfp_write && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (bus.dfp_write !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_stall: dfp_write=%b expected 1", bus.dfp_write);
    end
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.dfp_write !== 1'b0 || bus.busy !== 1'b0 || bus.setup !== 2'd0) begin
      miscompares++;
      $display("FAIL rmid_abort: write=%b busy=%b setup=%0d expected 0/0/0", bus.dfp_write,
               bus.busy, bus.setup);
    end
    @(negedge clk);
    rst = 1'b1;
    resp_delay = 0;
    run_req(1'b0, 2'd2, 300);
    vectors++;
    if (first_set !== 0) begin
      miscompares++;
      $display("FAIL rmid_restart: first set=%0d expected 0", first_set);
    end
    vectors++;
    if (wr_addr.size() !== 2) begin
      miscompares++;
      $display("FAIL rmid_count: got %0d expected 2", wr_addr.size());
    end else begin
      vectors++;
      if (wr_addr[0] !== 32'h0000_AAA0 || wr_addr[1] !== 32'h0001_3320) begin
        miscompares++;
        $display("FAIL rmid_addr: got %h %h expected 0000aaa0 00013320", wr_addr[0], wr_addr[1]);
      end
    end
    vectors++;
    if (lat !== 70 || bus.setup !== 2'd2) begin
      miscompares++;
      $display("FAIL rmid_done: lat=%0d setup=%0d expected 70/2", lat, bus.setup);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_mode  = 1'b0;
    bus.req_setup = 2'd0;
    clear_arrays();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_clean_flush();
    test_single_dirty();
    test_multi_dirty();
    test_skip();
    test_clean_mode();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
